mc_controller: RTL and testbench

Parametrised multicycle control unit for the ARMv4-subset processor. Replaces the single-cycle combinational decode with a state machine that sequences fetch, decode, execute, memory and writeback over one shared memory port. It also holds a flags register that conditional execution reads, and a request/ready memory handshake with a bounded wait. It sits between the instruction register and the multicycle datapath (PC, IR, register file, ALU, shared memory).

---
 rtl/mc_controller.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle FSM control unit for the ARMv4-subset core.
// Optional performance counters are enabled with `define MC_PERF_CNT_EN.
module mc_controller #(
    parameter int MAX_WAIT  = 15,
    parameter int CNT_WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] aluflags,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc,
    output logic [1:0] alucontrol,
    output logic       fault
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] instret,
    output logic [CNT_WIDTH-1:0] cycles
`endif
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_FAULT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [7:0] wait_q, wait_d;

    logic       n_f, z_f, c_f, v_f;
    logic       cond_ex;
    logic       cmd_ok;
    logic       is_cmp;
    logic       is_logic;
    logic [1:0] alu_op;
    logic       acc_c;

    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign acc_c = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_op   = 2'b00;
        cmd_ok   = 1'b1;
        is_cmp   = 1'b0;
        is_logic = 1'b0;
        unique case (funct[4:1])
            4'b0100: alu_op = 2'b00;
            4'b0010: alu_op = 2'b01;
            4'b0000: begin
                alu_op   = 2'b10;
                is_logic = 1'b1;
            end
            4'b1100: begin
                alu_op   = 2'b11;
                is_logic = 1'b1;
            end
            4'b1010: begin
                alu_op = 2'b01;
                is_cmp = 1'b1;
            end
            default: cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_ex) begin
                    state_d = S_FETCH;
                end else begin
                    unique case (op)
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI: begin
                // Logical ops leave C and V as they were.
                if (cmd_ok && (funct[0] || is_cmp)) begin
                    flags_d = is_logic ? {aluflags[3:2], flags_q[1:0]}
                                       : aluflags;
                end
                state_d = (cmd_ok && !is_cmp) ? S_ALUWB : S_FETCH;
            end
            S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FETCH;
        endcase

        if (acc_c && !mem_ready) begin
            if (wait_q == 8'(MAX_WAIT - 1)) begin
                state_d = S_FAULT;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end else begin
            wait_d = '0;
        end
        if (state_d != state_q) wait_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            flags_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        adrsrc     = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        immsrc     = 2'b00;
        regsrc     = 2'b00;
        alucontrol = 2'b00;
        fault      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                pcwrite   = mem_ready;
            end
            S_DECODE: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                regsrc  = 2'b01;
            end
            S_MEMADR: begin
                alusrcb = 2'b01;
                immsrc  = 2'b01;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                adrsrc   = 1'b1;
                regsrc   = 2'b10;
                memwrite = mem_ready;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                pcwrite   = (rd == 4'hF);
            end
            S_EXECR: alucontrol = alu_op;
            S_EXECI: begin
                alusrcb    = 2'b01;
                alucontrol = alu_op;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                pcwrite  = (rd == 4'hF);
            end
            S_BRANCH: begin
                alusrcb   = 2'b01;
                immsrc    = 2'b10;
                resultsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: fault = 1'b0;
        endcase

        // Outputs drop the moment reset asserts, not at the next edge.
        if (!reset_n) begin
            mem_req    = 1'b0;
            adrsrc     = 1'b0;
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            resultsrc  = 2'b00;
            immsrc     = 2'b00;
            regsrc     = 2'b00;
            alucontrol = 2'b00;
            fault      = 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycles_q;
    logic [CNT_WIDTH-1:0] instret_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_FAULT) begin
                cycles_q <= cycles_q + CNT_WIDTH'(1);
            end
            if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    assign cycles  = cycles_q;
    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed table, corner sequences and random
// instruction stream checked against an instruction-level model.
`timescale 1ns/1ps
module tb_mc_controller;
    localparam int MW = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] cond = '0;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;
    logic [3:0] rd = '0;
    logic [3:0] aluflags = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite;
    logic       alusrca, fault;
    logic [1:0] alusrcb, resultsrc, immsrc, regsrc, alucontrol;
`ifdef MC_PERF_CNT_EN
    logic [15:0] instret, cycles;
`endif

    always #5 clock = ~clock;

    mc_controller #(.MAX_WAIT(MW), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .cond(cond), .op(op),
        .funct(funct), .rd(rd), .aluflags(aluflags),
        .mem_ready(mem_ready), .mem_req(mem_req), .adrsrc(adrsrc),
        .irwrite(irwrite), .pcwrite(pcwrite), .memwrite(memwrite),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .resultsrc(resultsrc), .immsrc(immsrc), .regsrc(regsrc),
        .alucontrol(alucontrol), .fault(fault)
`ifdef MC_PERF_CNT_EN
        , .instret(instret), .cycles(cycles)
`endif
    );

    logic [17:0] ovec;
    assign ovec = {mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite,
                   alusrca, alusrcb, resultsrc, immsrc, regsrc,
                   alucontrol, fault};

    int checks = 0;
    int errors = 0;

    typedef struct {
        int len, rw, pw, mw, acc, wsum, alu, ir;
    } stat_t;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  af;
        int len, rw, pw, mw, alu;
    } vec_t;

    typedef struct {
        int len, rw, pw, mw, acc, alu;
    } exp_t;

    stat_t      st;
    bit         in_acc = 0;
    int         cur_w = 0;
    int         waited = 0;
    int         wq[$];
    logic [3:0] mflags = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle with a memory that answers after a chosen delay.
    task automatic step(input int maxw);
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        if (mem_req) begin
            if (!in_acc) begin
                in_acc = 1;
                waited = 0;
                if (wq.size() > 0) cur_w = wq.pop_front();
                else cur_w = $urandom_range(maxw, 0);
            end
            if (waited == cur_w) mem_ready = 1'b1;
        end
        #1;
        st.len++;
        st.rw  += int'(regwrite);
        st.pw  += int'(pcwrite);
        st.mw  += int'(memwrite);
        st.ir  += int'(irwrite);
        st.alu |= int'(alucontrol);
        if (mem_req && mem_ready) begin
            in_acc = 0;
            st.acc++;
            st.wsum += cur_w;
        end else if (mem_req) begin
            waited++;
        end
    endtask

    task automatic run_until_fetch(input int maxw);
        st = '{default: 0};
        for (int k = 0; k < 40; k++) begin
            step(maxw);
            if (st.ir > 0) break;
        end
        if (st.ir == 0) chk("fetch_timeout", 0, 1);
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af,
                             input int maxw, output stat_t s);
        cond     = ins[31:28];
        op       = ins[27:26];
        funct    = ins[25:20];
        rd       = ins[15:12];
        aluflags = af;
        run_until_fetch(maxw);
        s = st;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        in_acc  = 0;
        wq.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, b;
        {n, z, cc, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cc;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cc && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !b : b;
    endfunction

    // Instruction-level expectations; window ends with the next fetch.
    task automatic predict(input logic [31:0] ins, input logic [3:0] af,
                           output exp_t e);
        logic [3:0] c, cmd;
        logic [1:0] o;
        logic       s, wb;
        c   = ins[31:28];
        o   = ins[27:26];
        cmd = ins[24:21];
        s   = ins[20];
        wb  = 0;
        e   = '{len: 2, rw: 0, pw: 1, mw: 0, acc: 1, alu: 0};
        if (cond_ok(c, mflags) && o != 2'b11) begin
            if (o == 2'b10) begin
                e.len = 3;
                e.pw  = 2;
            end else if (o == 2'b01) begin
                e.acc = 2;
                if (s) begin
                    e.len = 5;
                    wb = 1;
                end else begin
                    e.len = 4;
                    e.mw  = 1;
                end
            end else begin
                e.len = 3;
                case (cmd)
                    4'd4: begin wb = 1; if (s) mflags = af; end
                    4'd2: begin wb = 1; e.alu = 1; if (s) mflags = af; end
                    4'd0: begin
                        wb = 1; e.alu = 2;
                        if (s) mflags[3:2] = af[3:2];
                    end
                    4'd12: begin
                        wb = 1; e.alu = 3;
                        if (s) mflags[3:2] = af[3:2];
                    end
                    4'd10: begin e.alu = 1; mflags = af; end
                    default: e.alu = 0;
                endcase
                if (wb) e.len = 4;
            end
            if (wb) begin
                e.rw = 1;
                if (ins[15:12] == 4'hF) e.pw++;
            end
        end
    endtask

    vec_t tbl[23];

    initial begin
        stat_t s;
        exp_t  e;
        int    nreq, mwseen, bad;
        logic [3:0] cmds[5];
        cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10};

        tbl[0]  = '{32'hE0821003, 4'h0, 4, 1, 1, 0, 0};
        tbl[1]  = '{32'hE0521003, 4'h4, 4, 1, 1, 0, 1};
        tbl[2]  = '{32'h00821003, 4'h0, 4, 1, 1, 0, 0};
        tbl[3]  = '{32'hE1510002, 4'h0, 3, 0, 1, 0, 1};
        tbl[4]  = '{32'h00821003, 4'h0, 2, 0, 1, 0, 0};
        tbl[5]  = '{32'hE5921004, 4'h0, 5, 1, 1, 0, 0};
        tbl[6]  = '{32'hE5821004, 4'h0, 4, 0, 1, 1, 0};
        tbl[7]  = '{32'hEAFFFFFE, 4'h0, 3, 0, 2, 0, 0};
        tbl[8]  = '{32'hE592F004, 4'h0, 5, 1, 2, 0, 0};
        tbl[9]  = '{32'hE082F003, 4'h0, 4, 1, 2, 0, 0};
        tbl[10] = '{32'hE1921003, 4'hF, 4, 1, 1, 0, 3};
        tbl[11] = '{32'h4AFFFFFE, 4'h0, 3, 0, 2, 0, 0};
        tbl[12] = '{32'h2AFFFFFE, 4'h0, 2, 0, 1, 0, 0};
        tbl[13] = '{32'hE0121003, 4'h3, 4, 1, 1, 0, 2};
        tbl[14] = '{32'hEC000000, 4'h0, 2, 0, 1, 0, 0};
        tbl[15] = '{32'hF0821003, 4'h0, 2, 0, 1, 0, 0};
        tbl[16] = '{32'hE2821004, 4'h0, 4, 1, 1, 0, 0};
        tbl[17] = '{32'hE0221003, 4'h0, 3, 0, 1, 0, 0};
        tbl[18] = '{32'hE0921003, 4'h3, 4, 1, 1, 0, 0};
        tbl[19] = '{32'hE0121003, 4'h8, 4, 1, 1, 0, 2};
        tbl[20] = '{32'h6AFFFFFE, 4'h0, 3, 0, 2, 0, 0};
        tbl[21] = '{32'hAAFFFFFE, 4'h0, 3, 0, 2, 0, 0};
        tbl[22] = '{32'h0AFFFFFE, 4'h0, 2, 0, 1, 0, 0};

        mem_ready = 1'b1;
        #12;
        chk("reset_outputs", int'(ovec), 0);
`ifdef MC_PERF_CNT_EN
        chk("reset_instret", int'(instret), 0);
        chk("reset_cycles", int'(cycles), 0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        run_until_fetch(0);

        foreach (tbl[i]) begin
            run_instr(tbl[i].ins, tbl[i].af, 0, s);
            chk($sformatf("tbl%0d_len", i), s.len, tbl[i].len);
            chk($sformatf("tbl%0d_regwrite", i), s.rw, tbl[i].rw);
            chk($sformatf("tbl%0d_pcwrite", i), s.pw, tbl[i].pw);
            chk($sformatf("tbl%0d_memwrite", i), s.mw, tbl[i].mw);
            chk($sformatf("tbl%0d_alucontrol", i), s.alu, tbl[i].alu);
        end

        wq = '{3, 0};
        run_instr(32'hE5921004, 4'h0, 0, s);
        chk("ldr_wait_len", s.len, 8);
        chk("ldr_wait_regwrite", s.rw, 1);
        chk("ldr_wait_accesses", s.acc, 2);

        do_reset();
        run_until_fetch(0);
        run_instr(32'hE0521003, 4'h4, 0, s);
        cond  = 4'h0;
        op    = 2'b00;
        funct = 6'b001000;
        rd    = 4'h1;
        bad   = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            mem_ready = 1'b1;
            #1;
            if (regwrite) begin
                bad = 0;
                break;
            end
        end
        chk("reached_aluwb", bad, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(ovec), 0);
        @(negedge clock);
        mem_ready = 1'b0;
        in_acc = 0;
        #1;
        chk("held_reset_outputs", int'(ovec), 0);
`ifdef MC_PERF_CNT_EN
        chk("held_reset_instret", int'(instret), 0);
`endif
        reset_n = 1'b1;
        #1;
        chk("fetch_after_reset", int'(ovec),
            int'({1'b1, 5'b0, 1'b1, 2'b10, 2'b10, 6'b0, 1'b0}));
        run_until_fetch(0);
        run_instr(32'h00821003, 4'h0, 0, s);
        chk("flags_cleared_eq_len", s.len, 2);
        chk("flags_cleared_eq_regwrite", s.rw, 0);

        mflags = 4'h0;
        for (int n = 0; n < 150; n++) begin
            logic [31:0] ins;
            logic [3:0]  cnd, af, rdv;
            logic [1:0]  opv;
            logic [5:0]  fn;
            cnd = $urandom_range(1, 0) ? 4'hE : 4'($urandom_range(15, 0));
            opv = 2'($urandom_range(3, 0));
            fn  = 6'($urandom_range(63, 0));
            if (opv == 2'b00 && $urandom_range(3, 0) != 0)
                fn[4:1] = cmds[$urandom_range(4, 0)];
            rdv = ($urandom_range(3, 0) == 0) ? 4'hF
                                               : 4'($urandom_range(14, 0));
            af  = 4'($urandom_range(15, 0));
            ins = {cnd, opv, fn, 4'h0, rdv, 12'h000};
            predict(ins, af, e);
            run_instr(ins, af, 2, s);
            chk($sformatf("rnd%0d_len", n), s.len, e.len + s.wsum);
            chk($sformatf("rnd%0d_regwrite", n), s.rw, e.rw);
            chk($sformatf("rnd%0d_pcwrite", n), s.pw, e.pw);
            chk($sformatf("rnd%0d_memwrite", n), s.mw, e.mw);
            chk($sformatf("rnd%0d_accesses", n), s.acc, e.acc);
            chk($sformatf("rnd%0d_alucontrol", n), s.alu, e.alu);
        end

        do_reset();
        run_until_fetch(0);
        cond  = 4'hE;
        op    = 2'b01;
        funct = 6'b011000;
        rd    = 4'h1;
        nreq  = 0;
        mwseen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            mem_ready = 1'b0;
            #1;
            if (fault) break;
            nreq   += int'(mem_req);
            mwseen += int'(memwrite);
        end
        chk("fault_asserted", int'(fault), 1);
        chk("fault_unready_cycles", nreq, MW);
        chk("fault_no_memwrite", mwseen, 0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            mem_ready = 1'b1;
            #1;
            if (ovec != 18'h1) bad++;
        end
        chk("fault_sticky", bad, 0);
        do_reset();
        #1;
        chk("fault_cleared_by_reset", int'(fault), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
